prime_verify: RTL and testbench



---
 rtl/prime_verify.sv | 113 +++++++++++
 tb/tb_prime_verify.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prime_verify.sv
// Trial-division primality checker: one subtraction per cycle, done/verify_Out pulse for one cycle after RESULT.
// Latency is two edges for n<4 and at most a few hundred cycles for n<=255; start is ignored while busy.
module prime_verify (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] num_In,
  input  logic       guess_In,
  output logic       busy,
  output logic       done,
  output logic       is_prime,
  output logic       verify_Out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SUB    = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [7:0] n, n_nx;
  logic [7:0] r, r_nx;
  logic [4:0] d, d_nx;
  logic       g, g_nx;
  logic       flag, flag_nx;
  logic [9:0] d_sq;

  // Full 10-bit square so d=16 (256) is never truncated against n.
  assign d_sq = {5'd0, d} * {5'd0, d};
  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    n_nx     = n;
    r_nx     = r;
    d_nx     = d;
    g_nx     = g;
    flag_nx  = flag;
    case (state)
      IDLE: begin
        if (start) begin
          n_nx = num_In;
          g_nx = guess_In;
          d_nx = 5'd2;
          if (num_In < 8'd2) begin
            flag_nx  = 1'b0;
            state_nx = RESULT;
          end else if (num_In < 8'd4) begin
            flag_nx  = 1'b1;
            state_nx = RESULT;
          end else begin
            state_nx = CHECK;
          end
        end
      end
      CHECK: begin
        if (d_sq > {2'b00, n}) begin
          flag_nx  = 1'b1;
          state_nx = RESULT;
        end else begin
          r_nx     = n;
          state_nx = SUB;
        end
      end
      SUB: begin
        if (r >= {3'b000, d}) begin
          r_nx = r - {3'b000, d};
        end else if (r == 8'd0) begin
          flag_nx  = 1'b0;
          state_nx = RESULT;
        end else begin
          d_nx     = d + 5'd1;
          state_nx = CHECK;
        end
      end
      RESULT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n          <= 8'd0;
      r          <= 8'd0;
      d          <= 5'd0;
      g          <= 1'b0;
      flag       <= 1'b0;
      is_prime   <= 1'b0;
      done       <= 1'b0;
      verify_Out <= 1'b0;
    end else begin
      state      <= state_nx;
      n          <= n_nx;
      r          <= r_nx;
      d          <= d_nx;
      g          <= g_nx;
      flag       <= flag_nx;
      done       <= (state == RESULT);
      verify_Out <= (state == RESULT) && (g == flag);
      if (state == RESULT) begin
        is_prime <= flag;
      end
    end
  end

endmodule

// File: tb/tb_prime_verify.sv
// Scoreboard bench for prime_verify: stimulus pushes expected results, a negedge monitor pops on done.
module tb_prime_verify;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_In;
  logic       guess_In;
  logic       busy;
  logic       done;
  logic       is_prime;
  logic       verify_Out;

  typedef struct {
    int unsigned num;
    logic        exp_prime;
    logic        exp_verify;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  prime_verify dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_In     (num_In),
    .guess_In   (guess_In),
    .busy       (busy),
    .done       (done),
    .is_prime   (is_prime),
    .verify_Out (verify_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_prime(input int v);
    if (v < 2) return 1'b0;
    for (int k = 2; k * k <= v; k++) begin
      if (v % k == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (verify_Out && !done) begin
      n_err++;
      $display("FAIL verify_without_done: verify_Out=1, done=0");
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: is_prime=%0d, no result outstanding", is_prime);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("is_prime[n=%0d]", e.num), int'(is_prime), int'(e.exp_prime));
        check($sformatf("verify_Out[n=%0d]", e.num), int'(verify_Out), int'(e.exp_verify));
      end
    end
  end

  // Called at a negedge; returns at the negedge on which done is high.
  task automatic run(input int num, input logic gs, input logic exp_prime, input bit exact);
    int lat;
    exp_t e;
    e.num = num; e.exp_prime = exp_prime; e.exp_verify = (gs == exp_prime);
    sb_q.push_back(e);
    num_In   = 8'(num);
    guess_In = gs;
    start    = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 800);
    if (exact) check($sformatf("latency[n=%0d]", num), lat, 2);
    else       check($sformatf("latency_le_700[n=%0d]", num), int'(lat <= 700), 1);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_vec = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; num_In = 8'd0; guess_In = 1'b0;
    idle(3);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_is_prime", int'(is_prime), 0);
    check("reset_verify", int'(verify_Out), 0);
    rst = 1'b0;

    // First start accepted on the first edge after reset release.
    run(7, 1'b1, 1'b1, 1'b0);
    run(9, 1'b1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b1);
    run(0, 1'b0, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1, 1'b1);
    run(3, 1'b0, 1'b1, 1'b1);
    run(4, 1'b0, 1'b0, 1'b0);
    run(251, 1'b1, 1'b1, 1'b0);
    run(255, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("done_one_cycle", int'(done), 0);
    idle(4);
    check("is_prime_hold", int'(is_prime), 0);

    // Start while busy is ignored.
    begin
      exp_t e;
      e.num = 97; e.exp_prime = 1'b1; e.exp_verify = 1'b1;
      sb_q.push_back(e);
      num_In = 8'd97; guess_In = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      idle(3);
      num_In = 8'd4; guess_In = 1'b0; start = 1'b1;
      idle(2);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 800) begin
        @(negedge clk);
        lat++;
      end
      check("busy_start_done_seen", int'(done), 1);
      idle(40);
      check("busy_start_is_prime_hold", int'(is_prime), 1);
      check("busy_start_no_outstanding", sb_q.size(), 0);
    end

    // Reset mid-computation of 211 discards the result.
    num_In = 8'd211; guess_In = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    idle(50);
    check("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_is_prime", int'(is_prime), 0);
    check("mid_rst_done", int'(done), 0);
    idle(30);
    check("mid_rst_still_idle", int'(busy), 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; num_In = 8'd7; guess_In = 1'b1;
    @(negedge clk);
    check("rst_priority_busy", int'(busy), 0);
    rst = 1'b0;
    run(3, 1'b1, 1'b1, 1'b1);

    // Exhaustive sweep, back-to-back starts.
    for (int i = 0; i < 256; i++) begin
      run(i, 1'(i % 2), ref_prime(i), (i < 4));
    end
    idle(10);
    check("sweep_no_outstanding", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
